lfsr_serial_gen: RTL and testbench

// - Parametrised successor of the team's 4-bit LFSR: Fibonacci LFSR of WIDTH bits, programmable tap mask,
//   run length set per request, then LSB-first serial unload of the final state.
// - Sits between a control FSM (start/seed/run_len) and a serial sink (out_valid/out_ready backpressure).
// - Default parameters reproduce the legacy 4-bit sequence (feedback R[2]^R[1]^R[0] into MSB, shift right).

---
 rtl/lfsr_serial_gen_pkg.sv | 21 ++
 rtl/lfsr_serial_gen_core.sv | 18 +
 rtl/lfsr_serial_gen.sv | 112 +++++++++++
 tb/tb_lfsr_serial_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_serial_gen_pkg.sv
// lfsr_serial_gen_pkg
//   Shared definitions for the LFSR serial generator family: FSM state
//   encoding, the legacy 4-bit tap constant and counter width helpers.
package lfsr_serial_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SERIAL = 2'd2,
    ST_DONE   = 2'd3
  } lfsr_state_t;

  // Legacy 4-bit LFSR feedback: R[2]^R[1]^R[0] into the MSB.
  localparam logic [3:0] LFSR4_TAPS = 4'b0111;

  // Bits needed to count 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lfsr_serial_gen_core.sv
// lfsr_core
//   Pure combinational Fibonacci LFSR step: shift right, feedback into MSB.
//   Ports:
//     state      in  WIDTH  current register value
//     next_state out WIDTH  {^(state & TAPS), state[WIDTH-1:1]}
module lfsr_core
  import lfsr_serial_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR4_TAPS)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  assign next_state = {^(state & TAPS), state[WIDTH-1:1]};

endmodule

// File: rtl/lfsr_serial_gen.sv
// lfsr_serial_gen
//   Fibonacci LFSR (WIDTH bits, TAPS mask) run for a per-request number of
//   shift cycles, then unloaded LSB-first over a valid/ready serial port.
//   Ports:
//     CLK        in   clock, rising edge
//     RST        in   asynchronous active-low reset
//     start      in   request pulse, sampled only in IDLE
//     seed       in   initial LFSR state (zero is replaced by 1)
//     run_len    in   number of LFSR shift cycles
//     out_ready  in   sink accepts out_bit this cycle
//     busy       out  high in every state except IDLE
//     out_valid  out  out_bit valid (SERIAL)
//     out_bit    out  current serial bit = R[0]
//     done       out  one-cycle pulse after last bit accepted
//     seed_fix   out  sticky per request: zero seed was replaced by 1
module lfsr_serial_gen
  import lfsr_serial_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR4_TAPS),
  parameter int unsigned      RUN_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [RUN_W-1:0] run_len,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic             out_bit,
  output logic             done,
  output logic             seed_fix
);

  localparam int unsigned BIT_W = cnt_w(WIDTH);

  lfsr_state_t      state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_next;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_len_q;
  logic [BIT_W-1:0] bit_cnt;
  logic             seed_fix_q;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .state      (r),
    .next_state (r_next)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      r          <= '0;
      run_cnt    <= '0;
      run_len_q  <= '0;
      bit_cnt    <= '0;
      seed_fix_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (seed == '0) begin
              r          <= WIDTH'(1);
              seed_fix_q <= 1'b1;
            end else begin
              r          <= seed;
              seed_fix_q <= 1'b0;
            end
            run_cnt   <= '0;
            bit_cnt   <= '0;
            run_len_q <= run_len;
            state     <= (run_len != '0) ? ST_RUN : ST_SERIAL;
          end
        end
        ST_RUN: begin
          r       <= r_next;
          run_cnt <= run_cnt + RUN_W'(1);
          // run_len_q is non-zero here, so the decrement cannot underflow.
          if (run_cnt == run_len_q - RUN_W'(1)) begin
            state <= ST_SERIAL;
          end
        end
        ST_SERIAL: begin
          if (out_ready) begin
            r       <= r >> 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(WIDTH - 1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state; reset values fall out of
  // state=IDLE and r=0.
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_SERIAL);
  assign done      = (state == ST_DONE);
  assign out_bit   = r[0];
  assign seed_fix  = seed_fix_q;

endmodule

// File: tb/tb_lfsr_serial_gen.sv
module tb_lfsr_serial_gen;

  logic       CLK;
  logic       RST;
  logic       start;
  logic [3:0] seed;
  logic [7:0] run_len;
  logic       out_ready;
  logic       busy;
  logic       out_valid;
  logic       out_bit;
  logic       done;
  logic       seed_fix;

  int errors = 0;
  int checks = 0;

  lfsr_serial_gen #(
    .WIDTH (4),
    .TAPS  (4'b0111),
    .RUN_W (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .seed      (seed),
    .run_len   (run_len),
    .out_ready (out_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .done      (done),
    .seed_fix  (seed_fix)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drives one request and collects the serial bits. Edge count 1 is the
  // start edge. Optionally stalls out_ready for stall_n cycles once stall_at
  // bits have been accepted, and optionally keeps start asserted (with a
  // different seed/run_len) for the whole request.
  task automatic run_request(input logic [3:0] s, input logic [7:0] len,
                             input int stall_at, input int stall_n,
                             input bit hold_start,
                             output logic [3:0] bits, output int t_valid,
                             output int t_done, output bit hold_ok);
    int   edges;
    int   nbits;
    int   stall_left;
    logic stall_ref;
    bits = '0; t_valid = -1; t_done = -1; hold_ok = 1'b1;
    nbits = 0; stall_left = stall_n; stall_ref = 1'b0;
    seed = s; run_len = len; start = 1'b1; out_ready = 1'b0;
    @(posedge CLK); #1;
    edges = 1;
    if (hold_start) begin
      seed = ~s; run_len = 8'd3;
    end else begin
      start = 1'b0;
    end
    while (edges < 300 && t_done < 0) begin
      if (done) begin
        t_done = edges;
        start  = 1'b0;
      end else begin
        if (out_valid && t_valid < 0) t_valid = edges;
        out_ready = 1'b1;
        if (out_valid && nbits == stall_at && stall_left > 0) begin
          if (stall_left == stall_n) stall_ref = out_bit;
          else if (out_bit !== stall_ref) hold_ok = 1'b0;
          out_ready = 1'b0;
          stall_left--;
        end
        if (out_valid && out_ready) begin
          if (nbits < 4) bits[nbits] = out_bit;
          nbits++;
        end
        @(posedge CLK); #1;
        edges++;
      end
    end
    out_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (t_done < 0) begin
      errors++;
      $display("FAIL done_timeout: done not seen within %0d edges", edges);
    end
    checks++;
    if (nbits != 4) begin
      errors++;
      $display("FAIL bit_count: got %0d bits, expected 4", nbits);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; start = 1'b0; seed = '0; run_len = '0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({busy, out_valid, out_bit, done, seed_fix} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {busy, out_valid, out_bit, done, seed_fix});
    end
    RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_legacy();
    logic [3:0] bits; int tv; int td; bit ok;
    run_request(4'b1001, 8'd8, -1, 0, 1'b0, bits, tv, td, ok);
    checks++;
    if (bits !== 4'b1100) begin
      errors++; $display("FAIL legacy_bits: got %b expected 1100 (LSB first)", bits);
    end
    checks++;
    if (tv != 9) begin
      errors++; $display("FAIL legacy_valid_latency: got %0d expected 9", tv);
    end
    checks++;
    if (td != 13) begin
      errors++; $display("FAIL legacy_done_latency: got %0d expected 13", td);
    end
    checks++;
    if (busy !== 1'b0 || seed_fix !== 1'b0) begin
      errors++; $display("FAIL legacy_idle: busy=%b seed_fix=%b expected 0 0", busy, seed_fix);
    end
  endtask

  task automatic test_zero_run();
    logic [3:0] bits; int tv; int td; bit ok;
    run_request(4'b1010, 8'd0, -1, 0, 1'b0, bits, tv, td, ok);
    checks++;
    if (bits !== 4'b1010) begin
      errors++; $display("FAIL zero_run_bits: got %b expected 1010", bits);
    end
    checks++;
    if (tv != 1) begin
      errors++; $display("FAIL zero_run_valid_latency: got %0d expected 1", tv);
    end
    checks++;
    if (td != 5) begin
      errors++; $display("FAIL zero_run_done_latency: got %0d expected 5", td);
    end
  endtask

  task automatic test_zero_seed();
    logic [3:0] bits; int tv; int td; bit ok;
    run_request(4'b0000, 8'd1, -1, 0, 1'b0, bits, tv, td, ok);
    checks++;
    if (bits !== 4'b1000) begin
      errors++; $display("FAIL zero_seed_bits: got %b expected 1000", bits);
    end
    checks++;
    if (td != 6) begin
      errors++; $display("FAIL zero_seed_done_latency: got %0d expected 6", td);
    end
    checks++;
    if (seed_fix !== 1'b1) begin
      errors++; $display("FAIL seed_fix_sticky: got %b expected 1", seed_fix);
    end
    // Next accepted start with a non-zero seed clears the flag.
    seed = 4'b0011; run_len = 8'd2; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    checks++;
    if (seed_fix !== 1'b0) begin
      errors++; $display("FAIL seed_fix_clear: got %b expected 0", seed_fix);
    end
    out_ready = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] bits; int tv; int td; bit ok;
    run_request(4'b1001, 8'd8, 1, 5, 1'b0, bits, tv, td, ok);
    checks++;
    if (bits !== 4'b1100) begin
      errors++; $display("FAIL bp_bits: got %b expected 1100", bits);
    end
    checks++;
    if (td != 18) begin
      errors++; $display("FAIL bp_done_latency: got %0d expected 18", td);
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL bp_hold: out_bit changed during stall, got %b expected 1", ok);
    end
  endtask

  task automatic test_ignored_start();
    logic [3:0] bits; int tv; int td; bit ok;
    run_request(4'b1001, 8'd8, -1, 0, 1'b1, bits, tv, td, ok);
    checks++;
    if (bits !== 4'b1100) begin
      errors++; $display("FAIL busy_start_bits: got %b expected 1100", bits);
    end
    checks++;
    if (td != 13) begin
      errors++; $display("FAIL busy_start_done_latency: got %0d expected 13", td);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_serial();
    logic [3:0] bits; int tv; int td; bit ok; bit saw_done;
    seed = 4'b1001; run_len = 8'd8; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; out_ready = 1'b1;
    repeat (9) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_serial: out_valid=%b expected 1", out_valid);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, out_bit, done, seed_fix} !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b expected 00000",
               {busy, out_valid, out_bit, done, seed_fix});
    end
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
      if (done) saw_done = 1'b1;
    end
    RST = 1'b1;
    out_ready = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL reset_no_done: activity after reset, got %b expected 0", saw_done);
    end
    run_request(4'b1010, 8'd0, -1, 0, 1'b0, bits, tv, td, ok);
    checks++;
    if (bits !== 4'b1010 || td != 5) begin
      errors++; $display("FAIL post_reset_run: bits=%b done=%0d expected 1010 5", bits, td);
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_zero_run();
    test_zero_seed();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_serial();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
